// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard and stall controller for a five-stage in-order pipeline
//   (IF/ID/EX/MEM/WB). It resolves three hazard classes every cycle:
//     - data-memory wait (MEM stage not ready): whole front freezes,
//       WB receives a bubble so the register file is never written twice;
//     - taken branch / jump resolved in EX: the two younger stages are flushed;
//     - load-use: the ID instruction is held for one cycle and a bubble is
//       injected into EX.
//   A small FSM tracks memory waits and halts the core when the data memory
//   stays busy for MEM_TIMEOUT consecutive cycles. Two saturating counters
//   expose stall and flush activity.
//
// Parameters
//   MEM_TIMEOUT  consecutive memory-wait cycles that trigger HALT (2..255)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   id_rs1, id_rs2                    source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2          ID instruction actually reads rs1 / rs2
//   ex_mem_read, ex_rd                EX instruction is a load / its rd
//   ex_redirect                       taken branch or jump resolved in EX
//   mem_req, mem_ready                MEM access issued / completing
//   pc_en .. mem_wb_en                stage-register load enables
//   if_id_flush, id_ex_flush,
//   mem_wb_flush                      load a bubble into that stage register
//   state                             RUN=0, MEM_WAIT=1, HALT=2
//   mem_err                           sticky memory-timeout flag
//   stall_cnt, flush_cnt              saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic [1:0]       state,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] HALT     = 2'd2;

   // wait_cnt holds the number of stalled cycles already seen, so the edge
   // that completes the MEM_TIMEOUT-th stalled cycle sees MEM_TIMEOUT-1.
   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

   logic       mem_stall;
   logic       lu_hazard;
   logic       rs1_match;
   logic       rs2_match;
   logic [1:0] state_nxt;
   logic [7:0] wait_cnt;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   // ---------------- hazard detection ----------------
   assign mem_stall = mem_req & ~mem_ready;
   assign rs1_match = id_uses_rs1 & (id_rs1 == ex_rd);
   assign rs2_match = id_uses_rs2 & (id_rs2 == ex_rd);
   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign lu_hazard = ex_mem_read & (ex_rd != 5'd0) & (rs1_match | rs2_match);

   // ---------------- enables and flushes ----------------
   // Purely combinational so a hazard acts in the cycle it is detected.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (state == HALT) begin
         // Frozen for good; WB keeps taking bubbles so nothing retires.
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (mem_stall) begin
         // Everything upstream of WB freezes. The held instructions keep the
         // inputs stable, so a pending redirect or load-use is acted on in
         // the completing cycle rather than lost.
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         // The instruction causing a load-use hazard is on the wrong path,
         // so the redirect wins and no stall is needed.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu_hazard) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (!mem_stall) begin
               state_nxt = RUN;
            end else if (wait_cnt == WAIT_LIMIT) begin
               state_nxt = HALT;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         mem_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state != HALT) begin
            wait_cnt <= mem_stall ? wait_cnt + 8'd1 : 8'd0;
         end
         if (state != HALT && state_nxt == HALT) begin
            mem_err <= 1'b1;
         end
      end
   end

   // ---------------- performance counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
         if (if_id_flush) begin
            flush_cnt <= sat_inc(flush_cnt);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl. Two instances share all inputs: dut_a
//   uses default parameters, dut_b uses MEM_TIMEOUT=4 and CNT_W=4 for the
//   timeout and saturation scenarios. Inputs change just after the falling
//   edge; combinational outputs are checked 1 ns later, registered outputs
//   are checked at the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
   logic        ex_mem_read = 1'b0, ex_redirect = 1'b0;
   logic        mem_req = 1'b0, mem_ready = 1'b0;

   logic        pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
   logic        if_id_flush_a, id_ex_flush_a, mem_wb_flush_a, mem_err_a;
   logic [1:0]  state_a;
   logic [15:0] stall_cnt_a, flush_cnt_a;

   logic        pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
   logic        if_id_flush_b, id_ex_flush_b, mem_wb_flush_b, mem_err_b;
   logic [1:0]  state_b;
   logic [3:0]  stall_cnt_b, flush_cnt_b;

   logic [4:0]  en_a, en_b;
   logic [2:0]  fl_a, fl_b;
   assign en_a = {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a};
   assign fl_a = {if_id_flush_a, id_ex_flush_a, mem_wb_flush_a};
   assign en_b = {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b};
   assign fl_b = {if_id_flush_b, id_ex_flush_b, mem_wb_flush_b};

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pipeline_ctrl dut_a (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a),
      .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
      .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a),
      .mem_wb_flush(mem_wb_flush_a),
      .state(state_a), .mem_err(mem_err_a),
      .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
   );

   pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b),
      .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
      .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
      .mem_wb_flush(mem_wb_flush_b),
      .state(state_b), .mem_err(mem_err_b),
      .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
   );

   task automatic clear_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_redirect = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   // Leaves the bench just after a falling edge with reset released.
   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      total_cnt++;
      if (state_a !== 2'd0 || mem_err_a !== 1'b0) $display("FAIL reset_state: state=%0d mem_err=%b, want 0/0", state_a, mem_err_a);
      else pass_cnt++;
      total_cnt++;
      if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0) $display("FAIL reset_counters: stall=%0d flush=%0d, want 0/0", stall_cnt_a, flush_cnt_a);
      else pass_cnt++;
      total_cnt++;
      if (en_a !== 5'b11111 || fl_a !== 3'b000) $display("FAIL reset_outputs: en=%b fl=%b, want 11111/000", en_a, fl_a);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      apply_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      #1;
      total_cnt++;
      if (en_a !== 5'b00111 || fl_a !== 3'b010) $display("FAIL load_use_rs1: en=%b fl=%b, want 00111/010", en_a, fl_a);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      #1;
      total_cnt++;
      if (en_a !== 5'b11111 || fl_a !== 3'b000 || stall_cnt_a !== 16'd1) $display("FAIL load_use_after: en=%b fl=%b stall=%0d, want 11111/000/1", en_a, fl_a, stall_cnt_a);
      else pass_cnt++;
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
      #1;
      total_cnt++;
      if (en_a !== 5'b00111 || fl_a !== 3'b010) $display("FAIL load_use_rs2: en=%b fl=%b, want 00111/010", en_a, fl_a);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      #1;
      total_cnt++;
      if (stall_cnt_a !== 16'd2 || flush_cnt_a !== 16'd0) $display("FAIL load_use_cnt: stall=%0d flush=%0d, want 2/0", stall_cnt_a, flush_cnt_a);
      else pass_cnt++;
   endtask

   task automatic test_x0_unused();
      apply_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      #1;
      total_cnt++;
      if (en_a !== 5'b11111 || fl_a !== 3'b000) $display("FAIL x0_no_stall: en=%b fl=%b, want 11111/000", en_a, fl_a);
      else pass_cnt++;
      @(negedge clk);
      ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0; id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
      #1;
      total_cnt++;
      if (en_a !== 5'b11111 || fl_a !== 3'b000) $display("FAIL unused_rs1: en=%b fl=%b, want 11111/000", en_a, fl_a);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      #1;
      total_cnt++;
      if (stall_cnt_a !== 16'd0) $display("FAIL x0_stall_cnt: stall=%0d, want 0", stall_cnt_a);
      else pass_cnt++;
   endtask

   task automatic test_redirect();
      apply_reset();
      ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      #1;
      total_cnt++;
      if (en_a !== 5'b11111 || fl_a !== 3'b110) $display("FAIL redirect_lu: en=%b fl=%b, want 11111/110", en_a, fl_a);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      #1;
      total_cnt++;
      if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd0) $display("FAIL redirect_cnt: flush=%0d stall=%0d, want 1/0", flush_cnt_a, stall_cnt_a);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      ex_redirect = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ex_redirect = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; id_uses_rs2 = 1'b1;
      @(negedge clk);
      clear_inputs();
      #1;
      total_cnt++;
      if (flush_cnt_a !== 16'd2 || stall_cnt_a !== 16'd1) $display("FAIL back_to_back_cnt: flush=%0d stall=%0d, want 2/1", flush_cnt_a, stall_cnt_a);
      else pass_cnt++;
   endtask

   task automatic test_mem_wait();
      apply_reset();
      mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
      #1;
      total_cnt++;
      if (en_a !== 5'b00001 || fl_a !== 3'b001 || state_a !== 2'd0) $display("FAIL mem_stall_first: en=%b fl=%b state=%0d, want 00001/001/0", en_a, fl_a, state_a);
      else pass_cnt++;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         #1;
         total_cnt++;
         if (state_a !== 2'd1 || en_a !== 5'b00001 || fl_a !== 3'b001) $display("FAIL mem_wait_cyc%0d: state=%0d en=%b fl=%b, want 1/00001/001", i, state_a, en_a, fl_a);
         else pass_cnt++;
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      total_cnt++;
      if (state_a !== 2'd1 || en_a !== 5'b11111 || fl_a !== 3'b110) $display("FAIL mem_complete_redirect: state=%0d en=%b fl=%b, want 1/11111/110", state_a, en_a, fl_a);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      #1;
      total_cnt++;
      if (state_a !== 2'd0 || stall_cnt_a !== 16'd3 || flush_cnt_a !== 16'd1) $display("FAIL mem_wait_end: state=%0d stall=%0d flush=%0d, want 0/3/1", state_a, stall_cnt_a, flush_cnt_a);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      apply_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         #1;
         total_cnt++;
         if (state_b !== 2'd1 || mem_err_b !== 1'b0) $display("FAIL timeout_wait%0d: state=%0d mem_err=%b, want 1/0", i, state_b, mem_err_b);
         else pass_cnt++;
      end
      @(negedge clk);
      #1;
      total_cnt++;
      if (state_b !== 2'd2 || mem_err_b !== 1'b1 || stall_cnt_b !== 4'd4) $display("FAIL timeout_halt: state=%0d mem_err=%b stall=%0d, want 2/1/4", state_b, mem_err_b, stall_cnt_b);
      else pass_cnt++;
      total_cnt++;
      if (state_a !== 2'd1) $display("FAIL timeout_default_dut: state=%0d, want 1", state_a);
      else pass_cnt++;
      mem_req = 1'b0; ex_redirect = 1'b1;
      #1;
      total_cnt++;
      if (en_b !== 5'b00001 || fl_b !== 3'b001) $display("FAIL halt_outputs: en=%b fl=%b, want 00001/001", en_b, fl_b);
      else pass_cnt++;
      @(negedge clk);
      clear_inputs();
      mem_req = 1'b1;
      #1;
      total_cnt++;
      if (state_b !== 2'd2 || mem_err_b !== 1'b1 || state_a !== 2'd0) $display("FAIL halt_sticky: state_b=%0d mem_err=%b state_a=%0d, want 2/1/0", state_b, mem_err_b, state_a);
      else pass_cnt++;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (state_b !== 2'd0 || mem_err_b !== 1'b0 || stall_cnt_b !== 4'd0 || state_a !== 2'd0) $display("FAIL async_reset: state_b=%0d mem_err=%b stall_b=%0d state_a=%0d, want 0/0/0/0", state_b, mem_err_b, stall_cnt_b, state_a);
      else pass_cnt++;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_saturation();
      apply_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
      repeat (20) @(negedge clk);
      clear_inputs();
      #1;
      total_cnt++;
      if (stall_cnt_b !== 4'd15) $display("FAIL saturation_b: stall=%0d, want 15", stall_cnt_b);
      else pass_cnt++;
      total_cnt++;
      if (stall_cnt_a !== 16'd20) $display("FAIL saturation_a: stall=%0d, want 20", stall_cnt_a);
      else pass_cnt++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_use();
      test_x0_unused();
      test_redirect();
      test_back_to_back();
      test_mem_wait();
      test_timeout();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
